// File: rtl/wah_pkg.sv
// Shared constants for the wah output path: I2S frame geometry and the
// relationship between the system clock and the 96 kHz sample rate.
package wah_pkg;
  localparam int SAMPLE_WIDTH    = 24;
  localparam int BCLK_HALF       = 10;
  localparam int SLOT_BITS       = 25;
  localparam int FRAME_BITS      = 2 * SLOT_BITS;
  localparam int SYS_CLK_HZ      = 96_000_000;
  localparam int SAMPLE_RATE_HZ  = 96_000;
  localparam int CLKS_PER_SAMPLE = SYS_CLK_HZ / SAMPLE_RATE_HZ;

  localparam int CNT_W = $clog2(BCLK_HALF);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int IDX_W = $clog2(SAMPLE_WIDTH);

  // One I2S frame must last exactly one sample period, or the stream drifts.
  localparam bit FRAME_RATE_OK = (FRAME_BITS * 2 * BCLK_HALF == CLKS_PER_SAMPLE);

  // Position of frame bit b inside its channel slot.
  function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(SLOT_BITS)) ? b - BIT_W'(SLOT_BITS) : b;
  endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF system cycles and flags
// the cycle whose clock edge makes bclk fall.
module i2s_bclk_gen
  import wah_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic bclk_fall
);
  logic [CNT_W-1:0] count;
  logic             terminal;

  assign terminal  = (count == CNT_W'(BCLK_HALF - 1));
  assign bclk_fall = terminal && bclk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      bclk  <= 1'b0;
    end else if (terminal) begin
      count <= '0;
      bclk  <= ~bclk;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S stereo transmitter for the wah output: holds one filtered sample,
// loads it at each frame start and sends it MSB first on both channels.
module i2s_tx_serializer
  import wah_pkg::*;
(
  input  logic                    system_clock,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    flag_clear,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun,
  output logic                    overrun
);
  if (!FRAME_RATE_OK) begin : g_rate_check
    $error("I2S frame length does not equal one sample period");
  end

  logic                    bclk_fall;
  logic                    frame_load;
  logic [BIT_W-1:0]        b;
  logic [BIT_W-1:0]        b_next;
  logic [BIT_W-1:0]        pos;
  logic [IDX_W-1:0]        idx;
  logic                    lrclk_next;
  logic                    sdata_next;
  logic [SAMPLE_WIDTH-1:0] hold;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    hold_full;
  logic                    underrun_set;
  logic                    overrun_set;

  i2s_bclk_gen u_bclk_gen (
    .clk       (system_clock),
    .rst       (rst),
    .bclk      (bclk),
    .bclk_fall (bclk_fall)
  );

  // Input handshake: sample_valid is a one-cycle strobe with no back-pressure;
  // sample_in is taken in the cycle it is high and never stalled.
  assign frame_load   = bclk_fall && (b == BIT_W'(FRAME_BITS - 1));
  assign underrun_set = frame_load && !hold_full && !sample_valid;
  assign overrun_set  = sample_valid && hold_full && !frame_load;

  // Each falling edge drives the bit for the current b, so lrclk leads the
  // MSB by one BCLK and the old word still supplies the right-slot LSB.
  always_comb begin
    pos        = slot_pos(b);
    b_next     = frame_load ? '0 : b + 1'b1;
    lrclk_next = (b >= BIT_W'(SLOT_BITS));
    idx        = '0;
    sdata_next = 1'b0;
    if (pos != '0) begin
      idx        = IDX_W'(SAMPLE_WIDTH - int'(pos));
      sdata_next = word[idx];
    end
  end

  always_ff @(posedge system_clock) begin
    if (!rst) begin
      b         <= BIT_W'(FRAME_BITS - 1);
      lrclk     <= 1'b1;
      sdata     <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      word      <= '0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bclk_fall) begin
        b     <= b_next;
        lrclk <= lrclk_next;
        sdata <= sdata_next;
      end
      // A sample arriving on the load cycle bypasses the hold register.
      if (frame_load) begin
        if (sample_valid) begin
          word <= sample_in;
        end else if (hold_full) begin
          word <= hold;
        end
        hold_full <= 1'b0;
      end else if (sample_valid) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end
      underrun <= (underrun && !flag_clear) || underrun_set;
      overrun  <= (overrun && !flag_clear) || overrun_set;
    end
  end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Downstream output stage of the wah effect. It captures each 24-bit filtered sample (filter_out) produced at the 96 kHz sample rate and serializes it as a standard I2S stereo stream for the output DAC, with the mono sample copied to both channels. All logic runs on the 96 MHz system_clock. It generates BCLK and LRCLK internally, and reports underrun and overrun conditions.

Parameters:
SAMPLE_WIDTH, 24, sample word width; MSB sent first.
BCLK_HALF, 10, system_clock cycles per BCLK half-period (BCLK = 4.8 MHz).
SLOT_BITS, 25, BCLKs per channel slot: 1 I2S delay bit plus SAMPLE_WIDTH data bits.

Ports:
system_clock  in  1  96 MHz system clock; the only clock.
rst  in  1  synchronous, active-low reset.
sample_in  in  SAMPLE_WIDTH  filtered sample (filter_out of the wah), two's complement.
sample_valid  in  1  one-cycle strobe; sample_in is valid in this cycle.
flag_clear  in  1  one-cycle strobe that clears the sticky flags.
bclk  out  1  I2S bit clock.
lrclk  out  1  I2S word select: 0 = left, 1 = right.
sdata  out  1  I2S serial data.
underrun  out  1  sticky: a frame started with no fresh sample.
overrun  out  1  sticky: a second sample arrived before the first was consumed.

Behaviour:
- Clock and reset: one clock and one reset. Everything is clocked on system_clock rising edge. Reset is synchronous and active-low.
- Reset values:
  - bclk=0, lrclk=1, sdata=0, underrun=0, overrun=0.
  - Divider count=0, bit index b=2*SLOT_BITS-1 (49).
  - Hold register=0, hold_full=0, frame word=0.
- BCLK divider:
  - The count runs 0..BCLK_HALF-1. At terminal count, bclk toggles and the count wraps to 0.
  - After reset release, bclk rises after 10 cycles and falls after 20. Period is 20 cycles.
- Bit index: b advances 49→0 and then increments on every bclk high→low transition. The frame is 50 BCLKs = 1000 system cycles, which is exactly one 96 kHz sample period.
- Updates on each falling bclk: lrclk and sdata change only here.
  - lrclk = 0 for b 0..24, 1 for b 25..49.
  - Slot position p = b mod 25.
  - p=0: sdata=0 (I2S one-bit delay).
  - p=1..24: sdata = word[24-p], so MSB first and LSB at p=24.
- Capture:
  - On sample_valid, sample_in goes to the hold register and hold_full is set.
  - If hold_full is already set and the frame load is not in the same cycle, the new value overwrites the held one and overrun is set.
- Frame load (the cycle in which b wraps to 0):
  - If hold_full is set: word ← hold and hold_full is cleared.
  - If hold_full is clear: word is unchanged (last sample repeats) and underrun is set.
- Simultaneous sample_valid and frame load: sample_in bypasses straight into word. hold_full ends cleared. No underrun and no overrun.
- Both slots in a frame transmit the same word.
- flag_clear clears underrun and overrun. If a set event happens in the same cycle, the set wins.
- Reset mid-frame aborts the frame immediately. All state returns to reset values and a pending held sample is discarded.
- Latency: a sample captured before the frame load has its MSB on sdata 2 BCLKs (40 cycles) after the load edge. This is p=1, driven at the falling edge after b=0.

Decomposition:
- Shared package wah_pkg:
  - SAMPLE_WIDTH, BCLK_HALF, SLOT_BITS.
  - Derived FRAME_BITS = 2*SLOT_BITS.
  - Compile-time check that FRAME_BITS*2*BCLK_HALF equals system_clock/sample rate (1000).
- One natural sub-module, i2s_bclk_gen: the divider, bclk, and a one-cycle bclk_fall strobe.
- Capture/hold logic, bit index, lrclk/sdata logic and flags stay in the top module.

Test Plan:
1. Reset and idle: hold rst=0 for 5 cycles, release, no sample_valid.
   - At release: bclk=0, lrclk=1, sdata=0.
   - bclk first rises at cycle 10 and falls at cycle 20, with period 20.
   - underrun sets at the first frame load and sdata stays 0.
2. Single word: pulse sample_valid with 0xA5A5A5 before a frame load.
   - Left slot p=1..24 carries 1010_0101 repeated, MSB first. The right slot repeats it.
   - lrclk is 0 for 25 BCLKs, then 1 for 25. No flags set.
3. Steady stream: a new sample every 1000 cycles, offset 300 cycles from the load.
   - Every frame carries the matching sample.
   - underrun=0 and overrun=0 throughout 20 frames.
4. Overrun: pulse 0x123456 then 0x7FFFFF within one frame.
   - Next frame sends 0x7FFFFF and overrun=1.
   - flag_clear returns overrun to 0.
5. Bypass: assert sample_valid with 0x800001 exactly on the frame-load cycle.
   - The frame sends 0x800001, no underrun, and hold_full=0 afterwards.
6. Reset mid-frame: send 0xFFFFFF, assert rst at b=12.
   - Outputs return to reset values on the next edge.
   - After release, the first frame repeats word 0 and flags underrun.
